// File: rtl/prof_pkg.sv
// ---------------------------------------------------------------------------
// prof_pkg
//   Shared types and default widths for the ap_ctrl transaction profiler.
//   Contents:
//     PROF_CNT_W       default latency / transaction counter width
//     PROF_TRIP_W      default loop trip counter width
//     PROF_STATE_W     default kernel FSM state vector width (one-hot)
//     PROF_FIFO_DEPTH  default record FIFO depth (power of two, >= 2)
//     prof_state_t     profiler FSM states
//     prof_rec_t       one profiling record at the default widths
// ---------------------------------------------------------------------------
package prof_pkg;

    localparam int PROF_CNT_W      = 32;
    localparam int PROF_TRIP_W     = 16;
    localparam int PROF_STATE_W    = 4;
    localparam int PROF_FIFO_DEPTH = 8;

    // IDLE waits for ap_start, RUN tracks one kernel transaction.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } prof_state_t;

    // Record layout used by the FIFO: latency in the upper bits, trip count
    // in the lower bits. The top module packs records in the same order at
    // whatever widths it is parameterised with.
    typedef struct packed {
        logic [PROF_CNT_W-1:0]  latency;
        logic [PROF_TRIP_W-1:0] trip;
    } prof_rec_t;

endpackage

// File: rtl/prof_rec_fifo.sv
// ---------------------------------------------------------------------------
// prof_rec_fifo
//   Synchronous record FIFO for the profiler. Every storage entry is a
//   register that is cleared by reset, so the head data presented on
//   pop_data is a register output and reads as zero straight out of reset.
//   There is no write-to-read bypass: a pushed record becomes visible on
//   the cycle after the push.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   push       in   write push_data this cycle (ignored when full unless pop)
//   push_data  in   record to store
//   full       out  all DEPTH entries occupied
//   pop        in   discard the head entry this cycle (ignored when empty)
//   pop_data   out  head entry
//   empty      out  no entries stored
// ---------------------------------------------------------------------------
module prof_rec_fifo #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wrPtr_q;
    logic [AW:0]       rdPtr_q;
    logic              doPush;
    logic              doPop;

    // Pointers carry one extra wrap bit so full and empty are told apart
    // without a separate occupancy counter. A push into a full FIFO is
    // still accepted when the head is popped in the same cycle, because
    // the slot being written is the one being freed.
    always_comb begin
        empty  = (wrPtr_q == rdPtr_q);
        full   = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                 (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
        doPop  = pop && !empty;
        doPush = push && (!full || doPop);
    end

    assign pop_data = mem_q[rdPtr_q[AW-1:0]];

    // Storage and pointer update; reset clears the entries as well so the
    // head output is defined while the FIFO is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= push_data;
                wrPtr_q                <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ap_ctrl_txn_profiler.sv
// ---------------------------------------------------------------------------
// ap_ctrl_txn_profiler
//   Watches an HLS kernel's ap_ctrl_hs handshake and its one-hot FSM state
//   register. For every completed transaction it produces one record of
//   {latency, loop trip count} into a small FIFO that a downstream monitor
//   drains over a valid/ready port.
// Ports:
//   ap_clk          in   clock
//   ap_rst_n        in   asynchronous active-low reset
//   ap_start        in   kernel ap_start (observed only)
//   ap_done         in   kernel ap_done
//   ap_ready        in   kernel ap_ready (observed only, not needed here)
//   cur_state       in   kernel ap_CS_fsm
//   iter_end_state  in   one-hot code of the loop iteration-end state
//   rec_valid       out  a record is available at the FIFO head
//   rec_ready       in   consumer accepts the head record
//   rec_latency     out  start cycle to done cycle, inclusive
//   rec_trip        out  loop iterations completed in the transaction
//   busy            out  a transaction is being tracked
//   txn_count       out  completed transactions, including dropped records
//   drop_count      out  records lost because the FIFO was full
//   overflow        out  sticky, set by the first dropped record
// All counters saturate at all-ones rather than wrapping.
// ---------------------------------------------------------------------------
module ap_ctrl_txn_profiler
    import prof_pkg::*;
#(
    parameter int CNT_W      = PROF_CNT_W,
    parameter int TRIP_W     = PROF_TRIP_W,
    parameter int STATE_W    = PROF_STATE_W,
    parameter int FIFO_DEPTH = PROF_FIFO_DEPTH
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    input  logic               ap_done,
    input  logic               ap_ready,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_end_state,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [CNT_W-1:0]   rec_latency,
    output logic [TRIP_W-1:0]  rec_trip,
    output logic               busy,
    output logic [CNT_W-1:0]   txn_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               overflow
);

    localparam int REC_W = CNT_W + TRIP_W;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TRIP_W-1:0] TRIP_ONE = TRIP_W'(1);

    prof_state_t       state_q, state_d;
    logic [CNT_W-1:0]  latCnt_q, latCnt_d;
    logic [TRIP_W-1:0] tripCnt_q, tripCnt_d;
    logic              prevInEnd_q, prevInEnd_d;
    logic [CNT_W-1:0]  txnCnt_q;
    logic [CNT_W-1:0]  dropCnt_q;
    logic              overflow_q;

    logic [CNT_W-1:0]  latInc;
    logic [TRIP_W-1:0] tripInc;
    logic [CNT_W-1:0]  txnInc;
    logic [CNT_W-1:0]  dropInc;
    logic              inEnd;
    logic              iterEntry;

    logic              recPush;
    logic [CNT_W-1:0]  recLat;
    logic [TRIP_W-1:0] recTrip;
    logic              recDrop;
    logic              fifoPush;
    logic              fifoPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [REC_W-1:0]  fifoHead;

    // ap_ready carries no information the profiler needs beyond ap_done,
    // so it is tapped only to keep the port connected to something.
    logic              unusedApReady;
    assign unusedApReady = ap_ready;

    // Saturating increments: once a counter reaches all-ones it stays there.
    always_comb begin
        latInc  = (&latCnt_q)  ? latCnt_q  : latCnt_q  + CNT_ONE;
        tripInc = (&tripCnt_q) ? tripCnt_q : tripCnt_q + TRIP_ONE;
        txnInc  = (&txnCnt_q)  ? txnCnt_q  : txnCnt_q  + CNT_ONE;
        dropInc = (&dropCnt_q) ? dropCnt_q : dropCnt_q + CNT_ONE;
    end

    // An iteration is counted on the cycle the kernel enters its
    // iteration-end state, so an end state that lasts several cycles is
    // only counted once.
    always_comb begin
        inEnd     = |(cur_state & iter_end_state);
        iterEntry = inEnd && !prevInEnd_q;
    end

    // Profiler FSM next state. latCnt_q holds the cycles seen before the
    // current one, so the record latency on the done cycle is the
    // incremented value, which makes the count inclusive of both the start
    // and the done cycle. A done with ap_start still high returns to IDLE
    // for one cycle, and IDLE then starts the following transaction.
    always_comb begin
        state_d     = state_q;
        latCnt_d    = latCnt_q;
        tripCnt_d   = tripCnt_q;
        prevInEnd_d = prevInEnd_q;
        recPush     = 1'b0;
        recLat      = '0;
        recTrip     = '0;

        case (state_q)
            IDLE: begin
                if (ap_start && ap_done) begin
                    // Single-cycle kernel: start and done coincide.
                    recPush = 1'b1;
                    recLat  = CNT_ONE;
                    recTrip = '0;
                end else if (ap_start) begin
                    state_d     = RUN;
                    latCnt_d    = CNT_ONE;
                    tripCnt_d   = '0;
                    prevInEnd_d = 1'b0;
                end
            end
            RUN: begin
                latCnt_d    = latInc;
                tripCnt_d   = iterEntry ? tripInc : tripCnt_q;
                prevInEnd_d = inEnd;
                if (ap_done) begin
                    recPush = 1'b1;
                    recLat  = latCnt_d;
                    recTrip = tripCnt_d;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and per-transaction counters. Reset discards any
    // transaction in flight.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            latCnt_q    <= '0;
            tripCnt_q   <= '0;
            prevInEnd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            latCnt_q    <= latCnt_d;
            tripCnt_q   <= tripCnt_d;
            prevInEnd_q <= prevInEnd_d;
        end
    end

    // A record is lost only if the FIFO is full and the consumer is not
    // taking the head in the same cycle.
    always_comb begin
        fifoPop  = !fifoEmpty && rec_ready;
        fifoPush = recPush && (!fifoFull || fifoPop);
        recDrop  = recPush && fifoFull && !fifoPop;
    end

    // Transaction, drop and overflow bookkeeping. Dropped records still
    // count as completed transactions.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            txnCnt_q   <= '0;
            dropCnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (recPush) begin
                txnCnt_q <= txnInc;
            end
            if (recDrop) begin
                dropCnt_q  <= dropInc;
                overflow_q <= 1'b1;
            end
        end
    end

    prof_rec_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (FIFO_DEPTH)
    ) uRecFifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .push      (fifoPush),
        .push_data ({recLat, recTrip}),
        .full      (fifoFull),
        .pop       (fifoPop),
        .pop_data  (fifoHead),
        .empty     (fifoEmpty)
    );

    assign rec_valid   = !fifoEmpty;
    assign rec_latency = fifoHead[REC_W-1:TRIP_W];
    assign rec_trip    = fifoHead[TRIP_W-1:0];
    assign busy        = (state_q == RUN);
    assign txn_count   = txnCnt_q;
    assign drop_count  = dropCnt_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_txn_profiler
//   Directed bench for the transaction profiler. The main instance uses the
//   default widths; a second instance with a 4-bit counter width exercises
//   saturation and the single-cycle kernel case. Inputs change 1 ns after
//   the rising edge and outputs are compared at the same point.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_txn_profiler;

    localparam logic [3:0] IDLE_ST  = 4'b0001;
    localparam logic [3:0] OTHER_ST = 4'b0010;
    localparam logic [3:0] END_ST   = 4'b0100;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_ready;
    logic [3:0]  cur_state;
    logic [3:0]  iter_end_state;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_latency;
    logic [15:0] rec_trip;
    logic        busy;
    logic [31:0] txn_count;
    logic [31:0] drop_count;
    logic        overflow;

    logic        d4Start;
    logic        d4Done;
    logic [3:0]  d4State;
    logic        d4Valid;
    logic        d4Ready;
    logic [3:0]  d4Latency;
    logic [15:0] d4Trip;
    logic        d4Busy;
    logic [3:0]  d4TxnCount;
    logic [3:0]  d4DropCount;
    logic        d4Overflow;

    int          checkCnt;
    int          passCnt;
    int          failCnt;
    logic        preDoneValid;

    ap_ctrl_txn_profiler dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_ready       (ap_ready),
        .cur_state      (cur_state),
        .iter_end_state (iter_end_state),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_latency    (rec_latency),
        .rec_trip       (rec_trip),
        .busy           (busy),
        .txn_count      (txn_count),
        .drop_count     (drop_count),
        .overflow       (overflow)
    );

    ap_ctrl_txn_profiler #(
        .CNT_W (4)
    ) dut4 (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .ap_start       (d4Start),
        .ap_done        (d4Done),
        .ap_ready       (d4Done),
        .cur_state      (d4State),
        .iter_end_state (iter_end_state),
        .rec_valid      (d4Valid),
        .rec_ready      (d4Ready),
        .rec_latency    (d4Latency),
        .rec_trip       (d4Trip),
        .busy           (d4Busy),
        .txn_count      (d4TxnCount),
        .drop_count     (d4DropCount),
        .overflow       (d4Overflow)
    );

    // 100 MHz clock.
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // One comparison: counts it, steps the pass count, reports a failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCnt++;
        assert (observed === expected) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic applyReset();
        ap_rst_n = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();
    endtask

    // Drives one kernel transaction of lat cycles (lat >= 2). Cycle c of
    // the transaction shows the iteration-end state when endMask[c] is set.
    task automatic applyStimulus(input int lat, input logic [15:0] endMask,
                                 input bit holdStart, input bit readyAtDone);
        for (int c = 1; c <= lat; c++) begin
            ap_start  = (c == 1) ? 1'b1 : holdStart;
            ap_done   = (c == lat);
            ap_ready  = (c == lat);
            cur_state = endMask[c] ? END_ST : OTHER_ST;
            if (c == lat) begin
                preDoneValid = rec_valid;
                if (readyAtDone) rec_ready = 1'b1;
            end
            tick();
        end
        ap_start  = holdStart;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        cur_state = IDLE_ST;
        rec_ready = 1'b0;
    endtask

    // Checks the head record then pops it.
    task automatic drainOne(input string tag, input int expLat, input int expTrip);
        checkOutput({tag, ".valid"}, 64'(rec_valid), 64'd1);
        checkOutput({tag, ".latency"}, 64'(rec_latency), 64'(expLat));
        checkOutput({tag, ".trip"}, 64'(rec_trip), 64'(expTrip));
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
    endtask

    initial begin
        checkCnt       = 0;
        passCnt        = 0;
        failCnt        = 0;
        preDoneValid   = 1'b0;
        ap_rst_n       = 1'b1;
        ap_start       = 1'b0;
        ap_done        = 1'b0;
        ap_ready       = 1'b0;
        cur_state      = IDLE_ST;
        iter_end_state = END_ST;
        rec_ready      = 1'b0;
        d4Start        = 1'b0;
        d4Done         = 1'b0;
        d4State        = IDLE_ST;
        d4Ready        = 1'b0;
        #2;

        applyReset();
        $display("[TB] reset state");
        checkOutput("rst.valid", 64'(rec_valid), 64'd0);
        checkOutput("rst.latency", 64'(rec_latency), 64'd0);
        checkOutput("rst.trip", 64'(rec_trip), 64'd0);
        checkOutput("rst.busy", 64'(busy), 64'd0);
        checkOutput("rst.txn", 64'(txn_count), 64'd0);
        checkOutput("rst.drop", 64'(drop_count), 64'd0);
        checkOutput("rst.overflow", 64'(overflow), 64'd0);

        // Single transaction, done at cycle 7. End state entered at cycle 2
        // (held through 3), 5 and 7 (done cycle) -> 3 iterations.
        $display("[TB] single transaction");
        applyStimulus(7, 16'h00AC, 1'b0, 1'b0);
        checkOutput("t1.noBypass", 64'(preDoneValid), 64'd0);
        checkOutput("t1.txn", 64'(txn_count), 64'd1);
        checkOutput("t1.busy", 64'(busy), 64'd0);
        drainOne("t1", 7, 3);
        checkOutput("t1.emptyAfter", 64'(rec_valid), 64'd0);

        // Back-to-back with ap_start held. First ends in the end state; the
        // second is in the end state on its start cycle and first RUN cycle,
        // which must count because the edge flag is cleared on start.
        $display("[TB] back-to-back transactions");
        applyStimulus(5, 16'h0028, 1'b1, 1'b0);
        applyStimulus(5, 16'h0006, 1'b0, 1'b0);
        checkOutput("t2.txn", 64'(txn_count), 64'd3);
        drainOne("t2a", 5, 2);
        drainOne("t2b", 5, 1);
        checkOutput("t2.emptyAfter", 64'(rec_valid), 64'd0);

        // Nine transactions into an 8-deep FIFO with the consumer stalled.
        $display("[TB] FIFO overflow");
        applyReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(2 + i, 16'h0000, 1'b0, 1'b0);
        end
        checkOutput("t3.txn", 64'(txn_count), 64'd9);
        checkOutput("t3.drop", 64'(drop_count), 64'd1);
        checkOutput("t3.overflow", 64'(overflow), 64'd1);
        checkOutput("t3.headLat", 64'(rec_latency), 64'd2);
        tick();
        tick();
        checkOutput("t3.headStable", 64'(rec_latency), 64'd2);
        checkOutput("t3.validStable", 64'(rec_valid), 64'd1);

        // Still full; consumer pops in the done cycle, so no drop.
        $display("[TB] full FIFO with pop at done");
        applyStimulus(11, 16'h0000, 1'b0, 1'b1);
        checkOutput("t4.drop", 64'(drop_count), 64'd1);
        checkOutput("t4.txn", 64'(txn_count), 64'd10);
        for (int i = 3; i <= 9; i++) begin
            drainOne("t4", i, 0);
        end
        drainOne("t4new", 11, 0);
        checkOutput("t4.empty", 64'(rec_valid), 64'd0);
        checkOutput("t4.overflowSticky", 64'(overflow), 64'd1);

        // Reset in the middle of a transaction.
        $display("[TB] reset mid-transaction");
        ap_start  = 1'b1;
        cur_state = OTHER_ST;
        tick();
        ap_start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("t5.busyBefore", 64'(busy), 64'd1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checkOutput("t5.busy", 64'(busy), 64'd0);
        checkOutput("t5.txn", 64'(txn_count), 64'd0);
        checkOutput("t5.drop", 64'(drop_count), 64'd0);
        checkOutput("t5.overflow", 64'(overflow), 64'd0);
        checkOutput("t5.valid", 64'(rec_valid), 64'd0);
        ap_done = 1'b1;
        tick();
        ap_rst_n = 1'b1;
        tick();
        ap_done = 1'b0;
        tick();
        checkOutput("t5.noRecord", 64'(rec_valid), 64'd0);
        checkOutput("t5.txnAfter", 64'(txn_count), 64'd0);
        applyStimulus(4, 16'h0008, 1'b0, 1'b0);
        drainOne("t5next", 4, 1);

        // 4-bit counter instance: single-cycle kernel, then saturation.
        $display("[TB] narrow counters");
        d4Start = 1'b1;
        d4Done  = 1'b1;
        d4State = OTHER_ST;
        tick();
        d4Start = 1'b0;
        d4Done  = 1'b0;
        checkOutput("t6.single.valid", 64'(d4Valid), 64'd1);
        checkOutput("t6.single.latency", 64'(d4Latency), 64'd1);
        checkOutput("t6.single.trip", 64'(d4Trip), 64'd0);
        checkOutput("t6.single.busy", 64'(d4Busy), 64'd0);
        checkOutput("t6.single.txn", 64'(d4TxnCount), 64'd1);
        d4Ready = 1'b1;
        tick();
        d4Ready = 1'b0;
        checkOutput("t6.popped", 64'(d4Valid), 64'd0);
        d4Start = 1'b1;
        tick();
        d4Start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
        end
        d4Done = 1'b1;
        tick();
        d4Done = 1'b0;
        checkOutput("t6.satLatency", 64'(d4Latency), 64'd15);
        checkOutput("t6.txn", 64'(d4TxnCount), 64'd2);
        d4Ready = 1'b1;
        tick();
        d4Ready = 1'b0;
        d4Start = 1'b1;
        d4Done  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        d4Start = 1'b0;
        d4Done  = 1'b0;
        checkOutput("t6.satTxn", 64'(d4TxnCount), 64'd15);
        checkOutput("t6.drop", 64'(d4DropCount), 64'd6);
        checkOutput("t6.overflow", 64'(d4Overflow), 64'd1);
        checkOutput("t6.headLat", 64'(d4Latency), 64'd1);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
